mcu_align_arbiter: RTL and testbench
====================================

# mcu_align_arbiter

Grant arbiter on the MCU side of the hyperfabric. It shares the DRAM port between the two aligned request lines, MCU_REQUEST_ALIGN[1:0] (also called DRAM_SEL), that the soft controller drives, and the refresh requests that the same controller toggles on MCU_REFRESH_STROBE. It returns MCU_GRANT_ALIGN[1:0] to the controller and issues the refresh command to the DRAM core. The goal is that block-mover transfers and refresh never overlap and that no refresh is lost.

## Interface
- TRFC, 8: cycles the REFRESH state occupies (≥2).
- TURNAROUND, 2: idle cycles after a grant is released (≥1).
- MAX_PENDING, 4: pending-refresh saturation level (≤7).
- CLK  in  1  single clock, all logic on posedge.
- RST  in  1  asynchronous, active-high reset.
- MCU_REQUEST_ALIGN  in  2  level request per alignment; held for the whole transfer.
- MCU_REFRESH_STROBE  in  1  toggle protocol; each edge is one refresh request.
- MCU_GRANT_ALIGN  out  2  one-hot or zero; grant for the matching request bit.
- DRAM_REFRESH_CMD  out  1  one-cycle pulse that starts a DRAM refresh.
- REFRESH_PENDING  out  3  count of refreshes not yet issued.
- REFRESH_OVERFLOW  out  1  sticky; a toggle arrived while the count was at MAX_PENDING.
- ARB_BUSY  out  1  high in every state except IDLE.

## Operation
- States: IDLE, GRANT0, GRANT1, TURN, REFRESH.
- Strobe detect: strobe_q registers MCU_REFRESH_STROBE; edge = strobe_q != MCU_REFRESH_STROBE.
- Each edge increments REFRESH_PENDING, saturating at MAX_PENDING.
- An edge seen while the count is at MAX_PENDING sets REFRESH_OVERFLOW. The flag clears only on RST.
- Edge in the same cycle as a refresh issue: the count is unchanged.
- IDLE priority order:
  - REFRESH_PENDING≠0 → REFRESH.
  - Otherwise, one request bit set → GRANT0 or GRANT1.
  - Otherwise, both bits set (illegal but defined) → round-robin on last_grant; reset value favours align 0.
- Entering REFRESH: DRAM_REFRESH_CMD pulses for one cycle and REFRESH_PENDING decrements. The state stays for TRFC cycles, then goes to IDLE.
- GRANTn: MCU_GRANT_ALIGN[n]=1 while MCU_REQUEST_ALIGN[n]=1.
- GRANTn release: on the first cycle the request bit is sampled 0 → TURN. This applies even if the other bit is now set. last_grant←n.
- TURN: held TURNAROUND cycles with no grant, then IDLE.
- Refresh toggles during a grant are counted but never preempt the grant. They are served in the first IDLE afterwards.
- Reset:
  - State IDLE; all outputs 0.
  - strobe_q samples MCU_REFRESH_STROBE on the first clock after reset release, so the current strobe level is not an edge.
  - last_grant=1.
  - Reset mid-grant drops the grant asynchronously.

## Timing
- Request first sampled high in IDLE (no refresh pending): grant is high on the next clock edge, 1-cycle latency.
- Request drop: grant falls on the next edge. The next grant is no earlier than TURNAROUND+2 cycles after the drop.
- Strobe edge in IDLE: REFRESH entered on the next edge, with DRAM_REFRESH_CMD high in that first REFRESH cycle. Next IDLE follows TRFC cycles later.
- All outputs are registered.
- MCU_GRANT_ALIGN never has both bits high.
- MCU_GRANT_ALIGN is never nonzero in the same cycle as DRAM_REFRESH_CMD or in any REFRESH cycle.
- Counters: turn/refresh timer is clog2(max(TRFC,TURNAROUND))+1 bits; pending counter is 3 bits with no wrap.

## Structure
- Shared package hf_mcu_pkg holds:
  - the arb_state_t enum (IDLE, GRANT0, GRANT1, TURN, REFRESH);
  - the default TRFC, TURNAROUND and MAX_PENDING constants;
  - the ALIGN0/ALIGN1 bit indices shared with the soft controller.
- One sub-module, refresh_pending_ctr, contains:
  - the toggle-edge detector;
  - the saturating up/down counter and the overflow flag.
- Inputs to refresh_pending_ctr: strobe and issue. Outputs: count and overflow.
- The arbiter FSM and timer stay in the top module.

## Test plan
- Reset, then MCU_REQUEST_ALIGN=01 for 10 cycles → GRANT=01 from cycle 2 to cycle 11; then 0 for 2 TURN cycles; ARB_BUSY matches.
- One strobe toggle in IDLE → DRAM_REFRESH_CMD single pulse on the next cycle; ARB_BUSY high 8 cycles; REFRESH_PENDING 1→0.
- Request 10 held 50 cycles with 3 strobe toggles during it → no pulse during the grant; PENDING=3; after release and TURN, three back-to-back REFRESH periods of 8 cycles; then PENDING=0.
- 6 toggles while align 0 is granted → PENDING saturates at 4, REFRESH_OVERFLOW=1 and stays 1 after the drain.
- Request 11 from reset → align 0 granted first; after drop/re-raise of both bits, align 1 is granted; never both grant bits at once.
- RST asserted mid-GRANT1 and mid-REFRESH → outputs 0 immediately; no spurious refresh pulse after release with a static strobe level.

Source files
------------

// File: rtl/hf_mcu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hf_mcu_pkg                                                               |
// | Shared arbiter state type, default timing constants and align indices.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package hf_mcu_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT0  = 3'd1,
    GRANT1  = 3'd2,
    TURN    = 3'd3,
    REFRESH = 3'd4
  } arb_state_t;

  localparam int c_TRFC        = 8;
  localparam int c_TURNAROUND  = 2;
  localparam int c_MAX_PENDING = 4;

  // Bit positions of the two aligned request lines, as seen by the soft controller.
  localparam int c_ALIGN0 = 0;
  localparam int c_ALIGN1 = 1;

endpackage : hf_mcu_pkg
`default_nettype wire

// File: rtl/refresh_pending_ctr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | refresh_pending_ctr                                                      |
// | Toggle-edge detector feeding a saturating pending-refresh counter.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module refresh_pending_ctr
  import hf_mcu_pkg::*;
#(
  parameter int MAX_PENDING = c_MAX_PENDING
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       strobe,
  input  logic       issue,
  output logic [2:0] count,
  output logic       overflow
);

  localparam logic [2:0] c_MAX = 3'(MAX_PENDING);

  logic r_strobe_q;
  logic r_armed;
  logic w_edge;

  // The first clock after reset only captures the strobe level, so a static level is never an edge.
  assign w_edge = r_armed && (r_strobe_q != strobe);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_strobe_q <= 1'b0;
      r_armed    <= 1'b0;
      count      <= 3'd0;
      overflow   <= 1'b0;
    end else begin
      r_strobe_q <= strobe;
      r_armed    <= 1'b1;
      if (w_edge && (count == c_MAX)) begin
        overflow <= 1'b1;
      end
      if (w_edge && !issue) begin
        if (count != c_MAX) begin
          count <= count + 3'd1;
        end
      end else if (issue && !w_edge) begin
        if (count != 3'd0) begin
          count <= count - 3'd1;
        end
      end
    end
  end

endmodule : refresh_pending_ctr
`default_nettype wire

// File: rtl/mcu_align_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mcu_align_arbiter                                                        |
// | Shares the DRAM port between two aligned requesters and refresh.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mcu_align_arbiter
  import hf_mcu_pkg::*;
#(
  parameter int TRFC        = c_TRFC,
  parameter int TURNAROUND  = c_TURNAROUND,
  parameter int MAX_PENDING = c_MAX_PENDING
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] MCU_REQUEST_ALIGN,
  input  logic       MCU_REFRESH_STROBE,
  output logic [1:0] MCU_GRANT_ALIGN,
  output logic       DRAM_REFRESH_CMD,
  output logic [2:0] REFRESH_PENDING,
  output logic       REFRESH_OVERFLOW,
  output logic       ARB_BUSY
);

  localparam int c_TMR_W = $clog2((TRFC > TURNAROUND) ? TRFC : TURNAROUND) + 1;

  arb_state_t         r_state;
  arb_state_t         w_next;
  logic [c_TMR_W-1:0] r_timer;
  logic [c_TMR_W-1:0] w_timer_next;
  logic               r_last_grant;
  logic               w_last_next;
  logic               w_issue;
  logic [1:0]         w_grant_next;
  logic [2:0]         w_pending;
  logic               w_overflow;

  refresh_pending_ctr #(
    .MAX_PENDING (MAX_PENDING)
  ) u_pending (
    .CLK      (CLK),
    .RST      (RST),
    .strobe   (MCU_REFRESH_STROBE),
    .issue    (w_issue),
    .count    (w_pending),
    .overflow (w_overflow)
  );

  assign REFRESH_PENDING  = w_pending;
  assign REFRESH_OVERFLOW = w_overflow;

  always_comb begin
    w_next       = r_state;
    w_timer_next = r_timer;
    w_last_next  = r_last_grant;
    w_issue      = 1'b0;
    w_grant_next = 2'b00;
    case (r_state)
      IDLE: begin
        if (w_pending != 3'd0) begin
          w_next       = REFRESH;
          w_timer_next = c_TMR_W'(TRFC - 1);
          w_issue      = 1'b1;
        end else if (MCU_REQUEST_ALIGN[c_ALIGN0] && MCU_REQUEST_ALIGN[c_ALIGN1]) begin
          // Both lines up is illegal; alternate away from whoever was served last.
          w_next = r_last_grant ? GRANT0 : GRANT1;
        end else if (MCU_REQUEST_ALIGN[c_ALIGN0]) begin
          w_next = GRANT0;
        end else if (MCU_REQUEST_ALIGN[c_ALIGN1]) begin
          w_next = GRANT1;
        end
      end
      GRANT0: begin
        if (!MCU_REQUEST_ALIGN[c_ALIGN0]) begin
          w_next       = TURN;
          w_timer_next = c_TMR_W'(TURNAROUND - 1);
          w_last_next  = 1'b0;
        end
      end
      GRANT1: begin
        if (!MCU_REQUEST_ALIGN[c_ALIGN1]) begin
          w_next       = TURN;
          w_timer_next = c_TMR_W'(TURNAROUND - 1);
          w_last_next  = 1'b1;
        end
      end
      TURN, REFRESH: begin
        if (r_timer == '0) begin
          w_next = IDLE;
        end else begin
          w_timer_next = r_timer - 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    w_grant_next[c_ALIGN0] = (w_next == GRANT0);
    w_grant_next[c_ALIGN1] = (w_next == GRANT1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state          <= IDLE;
      r_timer          <= '0;
      r_last_grant     <= 1'b1;
      MCU_GRANT_ALIGN  <= 2'b00;
      DRAM_REFRESH_CMD <= 1'b0;
      ARB_BUSY         <= 1'b0;
    end else begin
      r_state          <= w_next;
      r_timer          <= w_timer_next;
      r_last_grant     <= w_last_next;
      MCU_GRANT_ALIGN  <= w_grant_next;
      DRAM_REFRESH_CMD <= w_issue;
      ARB_BUSY         <= (w_next != IDLE);
    end
  end

endmodule : mcu_align_arbiter
`default_nettype wire

// File: tb/tb_mcu_align_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mcu_align_arbiter                                                     |
// | Directed and random stimulus against a cycle-level reference model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mcu_align_arbiter;

  localparam int c_TRFC = 8;
  localparam int c_TA   = 2;
  localparam int c_MAXP = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] req;
  logic       strobe;
  logic [1:0] grant;
  logic       cmd;
  logic [2:0] pend;
  logic       ovf;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // Reference: who owns the port (0 none, 1 align0, 2 align1, 3 refresh, 4 turnaround)
  int m_owner;
  int m_left;
  int m_pend;
  int m_ovf;
  int m_last;
  int m_cmd;
  int m_prev;
  int m_armed;

  always #5 CLK = ~CLK;

  mcu_align_arbiter #(
    .TRFC        (c_TRFC),
    .TURNAROUND  (c_TA),
    .MAX_PENDING (c_MAXP)
  ) dut (
    .CLK                (CLK),
    .RST                (RST),
    .MCU_REQUEST_ALIGN  (req),
    .MCU_REFRESH_STROBE (strobe),
    .MCU_GRANT_ALIGN    (grant),
    .DRAM_REFRESH_CMD   (cmd),
    .REFRESH_PENDING    (pend),
    .REFRESH_OVERFLOW   (ovf),
    .ARB_BUSY           (busy)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_left = 0; m_pend = 0; m_ovf = 0;
    m_last  = 1; m_cmd  = 0; m_armed = 0; m_prev = 0;
  endtask

  // Advance the reference across one rising edge with the given inputs.
  task automatic model_advance(input logic [1:0] r, input logic s);
    int edge_seen;
    int issue;
    edge_seen = (m_armed != 0) && (int'(s) != m_prev);
    m_prev  = int'(s);
    m_armed = 1;
    issue   = 0;
    case (m_owner)
      0: begin
        if (m_pend != 0) begin
          m_owner = 3; m_left = c_TRFC - 1; issue = 1;
        end else if (r == 2'b01) m_owner = 1;
        else if (r == 2'b10) m_owner = 2;
        else if (r == 2'b11) m_owner = (m_last == 1) ? 1 : 2;
      end
      1: if (!r[0]) begin m_owner = 4; m_left = c_TA - 1; m_last = 0; end
      2: if (!r[1]) begin m_owner = 4; m_left = c_TA - 1; m_last = 1; end
      default: begin
        if (m_left == 0) m_owner = 0;
        else m_left--;
      end
    endcase
    m_cmd = issue;
    if (edge_seen != 0 && m_pend == c_MAXP) m_ovf = 1;
    if (edge_seen != 0 && issue == 0) begin
      if (m_pend < c_MAXP) m_pend++;
    end else if (issue != 0 && edge_seen == 0) begin
      m_pend--;
    end
  endtask

  task automatic compare_all();
    int exp_grant;
    exp_grant = (m_owner == 1) ? 1 : (m_owner == 2) ? 2 : 0;
    check("grant", int'(grant), exp_grant);
    check("refresh_cmd", int'(cmd), m_cmd);
    check("pending", int'(pend), m_pend);
    check("overflow", int'(ovf), m_ovf);
    check("busy", int'(busy), (m_owner != 0) ? 1 : 0);
    check("grant_onehot", ((grant == 2'b11) || (cmd && grant != 2'b00)) ? 1 : 0, 0);
  endtask

  task automatic step(input logic [1:0] r, input logic s);
    @(negedge CLK);
    compare_all();
    req    = r;
    strobe = s;
    model_advance(r, s);
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge.
  task automatic do_reset();
    @(negedge CLK);
    compare_all();
    #2 RST = 1'b1;
    #1;
    check("rst_grant", int'(grant), 0);
    check("rst_cmd", int'(cmd), 0);
    check("rst_pending", int'(pend), 0);
    check("rst_overflow", int'(ovf), 0);
    check("rst_busy", int'(busy), 0);
    req = 2'b00;
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    model_advance(req, strobe);
  endtask

  initial begin
    logic       s;
    logic [1:0] rr;
    int         hold;
    RST    = 1'b1;
    req    = 2'b00;
    strobe = 1'b0;
    s      = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    check("reset_busy", int'(busy), 0);
    check("reset_grant", int'(grant), 0);
    RST = 1'b0;
    model_advance(req, strobe);

    // Single align-0 transfer followed by turnaround
    repeat (10) step(2'b01, s);
    repeat (5) step(2'b00, s);

    // One strobe toggle in IDLE
    s = ~s;
    step(2'b00, s);
    repeat (12) step(2'b00, s);

    // Toggles during a long align-1 grant are deferred
    for (int i = 0; i < 50; i++) begin
      if (i == 10 || i == 20 || i == 30) s = ~s;
      step(2'b10, s);
    end
    check("pending_during_grant", int'(pend), 3);
    repeat (32) step(2'b00, s);
    check("pending_drained", int'(pend), 0);

    // Saturation and sticky overflow
    for (int i = 0; i < 20; i++) begin
      if (i >= 4 && i < 16 && i[0]) s = ~s;
      step(2'b01, s);
    end
    check("pending_saturated", int'(pend), 4);
    check("overflow_set", int'(ovf), 1);
    repeat (40) step(2'b00, s);
    check("overflow_sticky", int'(ovf), 1);
    check("pending_after_drain", int'(pend), 0);

    // Both bits set: align 0 first after reset, then align 1
    do_reset();
    repeat (5) step(2'b11, s);
    repeat (4) step(2'b00, s);
    repeat (5) step(2'b11, s);
    repeat (4) step(2'b00, s);

    // Reset mid-GRANT1, then mid-REFRESH, with the strobe left static afterwards
    repeat (4) step(2'b10, s);
    do_reset();
    repeat (3) step(2'b00, s);
    s = ~s;
    step(2'b00, s);
    repeat (4) step(2'b00, s);
    do_reset();
    repeat (12) step(2'b00, s);
    check("no_spurious_pending", int'(pend), 0);

    // Randomized traffic
    hold = 0;
    rr   = 2'b00;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        rr   = 2'($urandom_range(0, 3));
        hold = $urandom_range(1, 20);
      end
      hold--;
      if ($urandom_range(0, 11) == 0) s = ~s;
      if (i == 300) do_reset();
      step(rr, s);
    end
    repeat (50) step(2'b00, s);

    @(negedge CLK);
    compare_all();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mcu_align_arbiter
`default_nettype wire
